riscv_i32_dmem_access_sequencer: RTL and testbench
==================================================

Name: riscv_i32_dmem_access_sequencer

Overview:
Sits directly downstream of the dmem request generator. Takes its per-access request (valid, type, address, byte enables, rotated write data, read-data rotation/enable/sign-extend, multicycle flag) and drives the data-memory port. For misaligned accesses that cross a word boundary it issues a second access. It merges the read data from both words, aligns and sign/zero-extends it, and returns a registered load result to the writeback stage.

Parameters:
ALLOW_MISALIGNED, 1, if 0 req_multicycle is ignored and every access is a single memory transaction

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-high reset
req_valid  input  1  access request from dmem request stage
req_ready  output  1  request accepted this cycle
req_is_store  input  1  1=store, 0=load
req_address  input  32  byte address
req_byte_enable  input  4  lane enables, already shifted by address[1:0] (upper bits truncated)
req_write_data  input  32  store data, already rotated to lanes
req_rotation  input  2  address[1:0] of access
req_read_byte_enable  input  4  result byte mask (1/3/f)
req_sign_extend_byte  input  1  LB
req_sign_extend_half  input  1  LH
req_multicycle  input  1  access crosses word boundary
req_rd  input  5  destination register
mem_valid  output  1  memory access request
mem_address  output  32  memory byte address
mem_write  output  1  1=write
mem_byte_enable  output  4  lane enables
mem_write_data  output  32  write data
mem_ack  input  1  memory accepted request this cycle
mem_rdata_valid  input  1  read data returned this cycle
mem_rdata  input  32  read data
mem_error  input  1  bus error, qualified by mem_rdata_valid
busy  output  1  state != IDLE
result_valid  output  1  load result pulse
result_error  output  1  load faulted (pulse with result_valid)
result_rd  output  5  destination register
result_data  output  32  aligned, extended load data
store_done  output  1  store fully issued (pulse)

Behaviour:
- Reset: state IDLE. All result_*, store_done and the capture registers are 0. Async reset mid-operation aborts any access. No result is produced for an aborted access.
- States: IDLE, FIRST_RESP, SECOND_REQ, SECOND_RESP.
- IDLE drives the memory port combinationally from req_*: mem_valid=req_valid, mem_address=req_address, be=req_byte_enable, data=req_write_data. req_ready = IDLE && mem_ack. On req_valid&&mem_ack the request fields are captured into internal registers.
- Load, not multicycle: IDLE -> FIRST_RESP. On mem_rdata_valid, result is registered, result_valid pulses next cycle, state -> IDLE.
- Load, multicycle: FIRST_RESP captures mem_rdata into buf0, -> SECOND_REQ. If mem_error is set instead, the error result is reported and the FSM returns to IDLE with no second access.
- SECOND_REQ:
  - mem_valid=1, mem_address={addr[31:2]+1,2'b00}; wraps 0xFFFFFFFC -> 0x00000000.
  - Second-access byte enable = upper nibble of (full_mask << rotation), full_mask = 1/3/f by access size. Write data = captured rotated data.
  - Holds until mem_ack, then -> SECOND_RESP for a load, or -> IDLE with store_done pulse next cycle for a store.
- Store, not multicycle: accepted in IDLE; store_done pulses next cycle, state stays IDLE. Stores expect no read response.
- SECOND_RESP on mem_rdata_valid builds merged word: lane i = buf0 lane i if i >= rotation, else mem_rdata lane i. Then -> IDLE.
- Result formation: rotate right by 8*rotation, AND with byte mask, sign-extend bit 7 (byte) or bit 15 (half) if flagged, else zero-extend.
- Error: result_error=1, result_data=0, result_valid=1.
- mem_rdata_valid while not in a *_RESP state is ignored. Single outstanding transaction only.
- Simultaneous result and new request: the result pulse in the IDLE-return cycle does not block a new request in that same cycle.

Test Plan:
- LW 0x100, mem_ack same cycle, rdata 0x11223344 next cycle -> result_valid 2 cycles after request, data 0x11223344, rd echoed.
- LB 0x103 signed, rdata 0x80000000 -> 0xFFFFFF80. LBU same access -> 0x00000080.
- LW 0x102 multicycle: second mem_address 0x104, be 0011. rdata 0xAABBCCDD then 0x11223344 -> result 0x3344AABB.
- SH 0x103 data 0xBEEF (pre-rotated 0xEFXXXXBE): first be 1000 @0x103, second be 0001 @0x104, then store_done pulse.
- LW 0xFFFFFFFE -> second address 0x00000000. mem_ack held low 3 cycles in SECOND_REQ -> mem_valid held, outputs stable.
- mem_error on first response of multicycle load -> result_error=1, data 0, no second access. Reset asserted in SECOND_RESP -> IDLE, no result_valid.

Source files
------------

// File: rtl/riscv_i32_dmem_access_sequencer.sv
// Data-memory port sequencer: issues one or two word accesses per request,
// merges split load data, aligns/extends it and returns a registered result.
module riscv_i32_dmem_access_sequencer #(
   parameter int ALLOW_MISALIGNED = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_is_store,
   input  logic [31:0] req_address,
   input  logic [3:0]  req_byte_enable,
   input  logic [31:0] req_write_data,
   input  logic [1:0]  req_rotation,
   input  logic [3:0]  req_read_byte_enable,
   input  logic        req_sign_extend_byte,
   input  logic        req_sign_extend_half,
   input  logic        req_multicycle,
   input  logic [4:0]  req_rd,
   output logic        mem_valid,
   output logic [31:0] mem_address,
   output logic        mem_write,
   output logic [3:0]  mem_byte_enable,
   output logic [31:0] mem_write_data,
   input  logic        mem_ack,
   input  logic        mem_rdata_valid,
   input  logic [31:0] mem_rdata,
   input  logic        mem_error,
   output logic        busy,
   output logic        result_valid,
   output logic        result_error,
   output logic [4:0]  result_rd,
   output logic [31:0] result_data,
   output logic        store_done
);

   typedef enum logic [1:0] {IDLE, FIRST_RESP, SECOND_REQ, SECOND_RESP} state_t;
   state_t state, state_next;

   logic        cap_is_store;
   logic [29:0] cap_word;
   logic [31:0] cap_wdata;
   logic [1:0]  cap_rot;
   logic [3:0]  cap_rmask;
   logic        cap_sx_byte;
   logic        cap_sx_half;
   logic        cap_mc;
   logic [4:0]  cap_rd;
   logic [31:0] buf0;

   logic        accept;
   logic        req_mc;
   logic        load_fire;
   logic        load_err;
   logic        store_fire;
   logic        buf0_load;
   logic [3:0]  be2;
   logic [31:0] merged;
   logic [31:0] raw_word;
   logic [31:0] rotated;
   logic [31:0] masked;
   logic [31:0] extended;

   assign accept = (state == IDLE) && req_valid && mem_ack;
   assign req_mc = req_multicycle && (ALLOW_MISALIGNED != 0);
   assign busy   = (state != IDLE);

   // Second-word lanes are the spill-over of the size mask shifted past lane 3.
   always_comb begin
      be2 = 4'b0000;
      case (cap_rot)
         2'd0: be2 = 4'b0000;
         2'd1: be2 = {3'b000, cap_rmask[3]};
         2'd2: be2 = {2'b00, cap_rmask[3:2]};
         2'd3: be2 = {1'b0, cap_rmask[3:1]};
         default: be2 = 4'b0000;
      endcase
   end

   // Lanes at or above the rotation come from the first word, the rest from the second.
   always_comb begin
      merged = mem_rdata;
      for (int i = 0; i < 4; i++) begin
         if (3'(i) >= {1'b0, cap_rot}) merged[8*i +: 8] = buf0[8*i +: 8];
      end
   end

   assign raw_word = (state == SECOND_RESP) ? merged : mem_rdata;

   always_comb begin
      rotated = raw_word;
      case (cap_rot)
         2'd0: rotated = raw_word;
         2'd1: rotated = {raw_word[7:0],  raw_word[31:8]};
         2'd2: rotated = {raw_word[15:0], raw_word[31:16]};
         2'd3: rotated = {raw_word[23:0], raw_word[31:24]};
         default: rotated = raw_word;
      endcase
      masked = rotated & {{8{cap_rmask[3]}}, {8{cap_rmask[2]}}, {8{cap_rmask[1]}}, {8{cap_rmask[0]}}};
      if (cap_sx_byte)      extended = {{24{masked[7]}}, masked[7:0]};
      else if (cap_sx_half) extended = {{16{masked[15]}}, masked[15:0]};
      else                  extended = masked;
   end

   always_comb begin
      state_next      = state;
      req_ready       = 1'b0;
      mem_valid       = 1'b0;
      mem_address     = req_address;
      mem_write       = req_is_store;
      mem_byte_enable = req_byte_enable;
      mem_write_data  = req_write_data;
      load_fire       = 1'b0;
      load_err        = 1'b0;
      store_fire      = 1'b0;
      buf0_load       = 1'b0;
      case (state)
         IDLE: begin
            mem_valid = req_valid;
            req_ready = mem_ack;
            if (accept) begin
               if (req_is_store) begin
                  if (req_mc) state_next = SECOND_REQ;
                  else        store_fire = 1'b1;
               end else begin
                  state_next = FIRST_RESP;
               end
            end
         end
         FIRST_RESP: begin
            if (mem_rdata_valid) begin
               if (mem_error || !cap_mc) begin
                  load_fire  = 1'b1;
                  load_err   = mem_error;
                  state_next = IDLE;
               end else begin
                  buf0_load  = 1'b1;
                  state_next = SECOND_REQ;
               end
            end
         end
         SECOND_REQ: begin
            mem_valid       = 1'b1;
            mem_address     = {cap_word + 30'd1, 2'b00};
            mem_write       = cap_is_store;
            mem_byte_enable = be2;
            mem_write_data  = cap_wdata;
            if (mem_ack) begin
               if (cap_is_store) begin
                  store_fire = 1'b1;
                  state_next = IDLE;
               end else begin
                  state_next = SECOND_RESP;
               end
            end
         end
         SECOND_RESP: begin
            if (mem_rdata_valid) begin
               load_fire  = 1'b1;
               load_err   = mem_error;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cap_is_store <= 1'b0;
         cap_word     <= '0;
         cap_wdata    <= '0;
         cap_rot      <= '0;
         cap_rmask    <= '0;
         cap_sx_byte  <= 1'b0;
         cap_sx_half  <= 1'b0;
         cap_mc       <= 1'b0;
         cap_rd       <= '0;
         buf0         <= '0;
      end else begin
         if (accept) begin
            cap_is_store <= req_is_store;
            cap_word     <= req_address[31:2];
            cap_wdata    <= req_write_data;
            cap_rot      <= req_rotation;
            cap_rmask    <= req_read_byte_enable;
            cap_sx_byte  <= req_sign_extend_byte;
            cap_sx_half  <= req_sign_extend_half;
            cap_mc       <= req_mc;
            cap_rd       <= req_rd;
         end
         if (buf0_load) buf0 <= mem_rdata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result_valid <= 1'b0;
         result_error <= 1'b0;
         result_rd    <= '0;
         result_data  <= '0;
         store_done   <= 1'b0;
      end else begin
         result_valid <= load_fire;
         result_error <= load_fire && load_err;
         store_done   <= store_fire;
         if (load_fire) begin
            result_rd   <= cap_rd;
            result_data <= load_err ? 32'h0 : extended;
         end
      end
   end

endmodule

// File: tb/tb_riscv_i32_dmem_access_sequencer.sv
// Directed bench for the dmem access sequencer: aligned, sub-word, split and
// faulting accesses, address wrap, ack stalls and mid-access reset.
module tb_riscv_i32_dmem_access_sequencer;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_is_store;
   logic [31:0] req_address;
   logic [3:0]  req_byte_enable;
   logic [31:0] req_write_data;
   logic [1:0]  req_rotation;
   logic [3:0]  req_read_byte_enable;
   logic        req_sign_extend_byte;
   logic        req_sign_extend_half;
   logic        req_multicycle;
   logic [4:0]  req_rd;
   logic        mem_valid;
   logic [31:0] mem_address;
   logic        mem_write;
   logic [3:0]  mem_byte_enable;
   logic [31:0] mem_write_data;
   logic        mem_ack;
   logic        mem_rdata_valid;
   logic [31:0] mem_rdata;
   logic        mem_error;
   logic        busy;
   logic        result_valid;
   logic        result_error;
   logic [4:0]  result_rd;
   logic [31:0] result_data;
   logic        store_done;

   int n_cmp = 0;
   int n_bad = 0;

   riscv_i32_dmem_access_sequencer dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
      .req_address(req_address), .req_byte_enable(req_byte_enable),
      .req_write_data(req_write_data), .req_rotation(req_rotation),
      .req_read_byte_enable(req_read_byte_enable),
      .req_sign_extend_byte(req_sign_extend_byte), .req_sign_extend_half(req_sign_extend_half),
      .req_multicycle(req_multicycle), .req_rd(req_rd),
      .mem_valid(mem_valid), .mem_address(mem_address), .mem_write(mem_write),
      .mem_byte_enable(mem_byte_enable), .mem_write_data(mem_write_data),
      .mem_ack(mem_ack), .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
      .mem_error(mem_error), .busy(busy),
      .result_valid(result_valid), .result_error(result_error),
      .result_rd(result_rd), .result_data(result_data), .store_done(store_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      req_valid = 0; req_is_store = 0; req_address = 0; req_byte_enable = 0;
      req_write_data = 0; req_rotation = 0; req_read_byte_enable = 0;
      req_sign_extend_byte = 0; req_sign_extend_half = 0; req_multicycle = 0;
      req_rd = 0; mem_ack = 0; mem_rdata_valid = 0; mem_rdata = 0; mem_error = 0;
   endtask

   task automatic drive_req(input logic st, input logic [31:0] a, input logic [3:0] be,
                            input logic [31:0] wd, input logic [1:0] rot, input logic [3:0] rm,
                            input logic sxb, input logic sxh, input logic mc, input logic [4:0] rd);
      req_valid = 1; req_is_store = st; req_address = a; req_byte_enable = be;
      req_write_data = wd; req_rotation = rot; req_read_byte_enable = rm;
      req_sign_extend_byte = sxb; req_sign_extend_half = sxh; req_multicycle = mc;
      req_rd = rd;
   endtask

   initial begin
      clear_inputs();
      reset = 1;
      #12;
      chk("rst_result_valid", {31'b0, result_valid}, 32'h0);
      chk("rst_result_error", {31'b0, result_error}, 32'h0);
      chk("rst_result_data", result_data, 32'h0);
      chk("rst_result_rd", {27'b0, result_rd}, 32'h0);
      chk("rst_store_done", {31'b0, store_done}, 32'h0);
      chk("rst_busy", {31'b0, busy}, 32'h0);
      reset = 0;
      step();

      // LW 0x100
      drive_req(0, 32'h100, 4'hF, 32'h0, 2'd0, 4'hF, 0, 0, 0, 5'd5);
      mem_ack = 1;
      #1;
      chk("lw_mem_valid", {31'b0, mem_valid}, 32'h1);
      chk("lw_mem_addr", mem_address, 32'h100);
      chk("lw_req_ready", {31'b0, req_ready}, 32'h1);
      step();
      clear_inputs();
      mem_rdata_valid = 1; mem_rdata = 32'h11223344;
      #1;
      chk("lw_busy", {31'b0, busy}, 32'h1);
      chk("lw_early_valid", {31'b0, result_valid}, 32'h0);
      step();
      clear_inputs();
      // New LB request in the same cycle the LW result pulses.
      drive_req(0, 32'h103, 4'b1000, 32'h0, 2'd3, 4'h1, 1, 0, 0, 5'd7);
      mem_ack = 1;
      #1;
      chk("lw_result_valid", {31'b0, result_valid}, 32'h1);
      chk("lw_result_data", result_data, 32'h11223344);
      chk("lw_result_rd", {27'b0, result_rd}, 32'd5);
      chk("b2b_req_ready", {31'b0, req_ready}, 32'h1);
      step();
      clear_inputs();
      mem_rdata_valid = 1; mem_rdata = 32'h80000000;
      #1;
      chk("lw_valid_drop", {31'b0, result_valid}, 32'h0);
      step();
      clear_inputs();
      #1;
      chk("lb_result_valid", {31'b0, result_valid}, 32'h1);
      chk("lb_result_data", result_data, 32'hFFFFFF80);
      chk("lb_result_rd", {27'b0, result_rd}, 32'd7);
      step();

      // LBU 0x103
      drive_req(0, 32'h103, 4'b1000, 32'h0, 2'd3, 4'h1, 0, 0, 0, 5'd8);
      mem_ack = 1;
      step();
      clear_inputs();
      mem_rdata_valid = 1; mem_rdata = 32'h80000000;
      step();
      clear_inputs();
      #1;
      chk("lbu_result_valid", {31'b0, result_valid}, 32'h1);
      chk("lbu_result_data", result_data, 32'h00000080);
      step();

      // LW 0x102 split
      drive_req(0, 32'h102, 4'b1100, 32'h0, 2'd2, 4'hF, 0, 0, 1, 5'd9);
      mem_ack = 1;
      #1;
      chk("lwm_be1", {28'b0, mem_byte_enable}, 32'hC);
      step();
      clear_inputs();
      mem_rdata_valid = 1; mem_rdata = 32'hAABBCCDD;
      #1;
      chk("lwm_resp_mem_valid", {31'b0, mem_valid}, 32'h0);
      step();
      clear_inputs();
      mem_ack = 1;
      #1;
      chk("lwm_second_valid", {31'b0, mem_valid}, 32'h1);
      chk("lwm_second_addr", mem_address, 32'h104);
      chk("lwm_second_be", {28'b0, mem_byte_enable}, 32'h3);
      chk("lwm_second_write", {31'b0, mem_write}, 32'h0);
      step();
      clear_inputs();
      mem_rdata_valid = 1; mem_rdata = 32'h11223344;
      step();
      clear_inputs();
      #1;
      chk("lwm_result_valid", {31'b0, result_valid}, 32'h1);
      chk("lwm_result_data", result_data, 32'h3344AABB);
      chk("lwm_result_rd", {27'b0, result_rd}, 32'd9);
      chk("lwm_result_error", {31'b0, result_error}, 32'h0);
      step();

      // SH 0x103 split store, data 0xBEEF rotated to lanes
      drive_req(1, 32'h103, 4'b1000, 32'hEF0000BE, 2'd3, 4'h3, 0, 0, 1, 5'd0);
      mem_ack = 1;
      #1;
      chk("sh_first_addr", mem_address, 32'h103);
      chk("sh_first_be", {28'b0, mem_byte_enable}, 32'h8);
      chk("sh_first_write", {31'b0, mem_write}, 32'h1);
      chk("sh_first_data", mem_write_data, 32'hEF0000BE);
      step();
      clear_inputs();
      mem_ack = 1;
      #1;
      chk("sh_second_addr", mem_address, 32'h104);
      chk("sh_second_be", {28'b0, mem_byte_enable}, 32'h1);
      chk("sh_second_data", mem_write_data, 32'hEF0000BE);
      chk("sh_second_write", {31'b0, mem_write}, 32'h1);
      chk("sh_no_early_done", {31'b0, store_done}, 32'h0);
      step();
      clear_inputs();
      #1;
      chk("sh_store_done", {31'b0, store_done}, 32'h1);
      chk("sh_busy_clear", {31'b0, busy}, 32'h0);
      step();
      chk("sh_done_drop", {31'b0, store_done}, 32'h0);

      // SW 0x200 single store
      drive_req(1, 32'h200, 4'hF, 32'h12345678, 2'd0, 4'hF, 0, 0, 0, 5'd0);
      mem_ack = 1;
      step();
      clear_inputs();
      #1;
      chk("sw_store_done", {31'b0, store_done}, 32'h1);
      chk("sw_busy", {31'b0, busy}, 32'h0);
      step();

      // LW 0xFFFFFFFE split with address wrap and ack stall
      drive_req(0, 32'hFFFFFFFE, 4'b1100, 32'h0, 2'd2, 4'hF, 0, 0, 1, 5'd3);
      mem_ack = 1;
      step();
      clear_inputs();
      mem_rdata_valid = 1; mem_rdata = 32'h55667788;
      step();
      for (int i = 0; i < 3; i++) begin
         clear_inputs();
         // Stray read data outside a response state must be ignored.
         mem_rdata_valid = (i == 1); mem_rdata = 32'hDEADBEEF;
         #1;
         chk("wrap_hold_valid", {31'b0, mem_valid}, 32'h1);
         chk("wrap_hold_addr", mem_address, 32'h0);
         chk("wrap_hold_be", {28'b0, mem_byte_enable}, 32'h3);
         step();
      end
      clear_inputs();
      mem_ack = 1;
      #1;
      chk("wrap_addr_ack", mem_address, 32'h0);
      step();
      clear_inputs();
      mem_rdata_valid = 1; mem_rdata = 32'h99AABBCC;
      step();
      clear_inputs();
      #1;
      chk("wrap_result_valid", {31'b0, result_valid}, 32'h1);
      chk("wrap_result_data", result_data, 32'hBBCC5566);
      step();

      // Split load faulting on its first response
      drive_req(0, 32'h102, 4'b1100, 32'h0, 2'd2, 4'hF, 0, 0, 1, 5'd11);
      mem_ack = 1;
      step();
      clear_inputs();
      mem_rdata_valid = 1; mem_error = 1; mem_rdata = 32'h12345678;
      step();
      clear_inputs();
      #1;
      chk("err_result_valid", {31'b0, result_valid}, 32'h1);
      chk("err_result_error", {31'b0, result_error}, 32'h1);
      chk("err_result_data", result_data, 32'h0);
      chk("err_result_rd", {27'b0, result_rd}, 32'd11);
      chk("err_no_second", {31'b0, mem_valid}, 32'h0);
      chk("err_busy", {31'b0, busy}, 32'h0);
      step();
      chk("err_error_drop", {31'b0, result_error}, 32'h0);

      // Reset while waiting for the second response
      drive_req(0, 32'h102, 4'b1100, 32'h0, 2'd2, 4'hF, 0, 0, 1, 5'd12);
      mem_ack = 1;
      step();
      clear_inputs();
      mem_rdata_valid = 1; mem_rdata = 32'hAABBCCDD;
      step();
      clear_inputs();
      mem_ack = 1;
      step();
      clear_inputs();
      #1;
      chk("rstmid_busy_before", {31'b0, busy}, 32'h1);
      reset = 1;
      #1;
      chk("rstmid_busy", {31'b0, busy}, 32'h0);
      chk("rstmid_result_valid", {31'b0, result_valid}, 32'h0);
      step();
      reset = 0;
      mem_rdata_valid = 1; mem_rdata = 32'h11223344;
      step();
      clear_inputs();
      #1;
      chk("rstmid_no_result", {31'b0, result_valid}, 32'h0);
      chk("rstmid_idle", {31'b0, busy}, 32'h0);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
